fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage. Holds the PC register and loads it from the `npc` value produced by the next-PC logic.
- Issues one-outstanding-request reads to instruction memory with variable latency.
- Delivers `{instr, pc}` to decode through a valid/ready IF/ID register.
- Supports flush/redirect from later stages; a dropped in-flight response is discarded.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- npc  in  32  next PC from the next-PC block; sampled on each accept event.
- pc  out  32  current fetch PC; fed back to the next-PC block.
- flush  in  1  redirect request; highest priority.
- flush_target  in  32  new PC when flush=1.
- imem_req  out  1  one-cycle read strobe.
- imem_addr  out  32  read address, equal to pc while imem_req=1.
- imem_rvalid  in  1  read data valid; at most one per request.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  IF/ID register holds an instruction.
- id_ready  in  1  decode consumes the IF/ID entry this cycle.
- id_instr  out  32  fetched instruction.
- id_pc  out  32  address of id_instr.
- id_exc  out  1  AdEL flag for id_instr (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0):
  - pc=PC_RESET, state=S_REQ, drop=0.
  - imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_exc=0, buffer empty.
- States: S_REQ, S_WAIT, S_HOLD.
  - S_REQ:
    - If slot_free, register imem_req=1 / imem_addr=pc for exactly one cycle, then go to S_WAIT.
    - Otherwise stay in S_REQ with imem_req=0.
    - slot_free = !id_valid || id_ready.
  - S_WAIT, imem_rvalid=1 and drop=0:
    - If slot_free: id_valid<=1, id_instr<=imem_rdata, id_pc<=pc, pc<=npc, go to S_REQ.
    - Otherwise latch imem_rdata into the one-entry buffer, pc<=npc, go to S_HOLD.
  - S_WAIT, imem_rvalid=1 and drop=1: discard data, drop<=0, go to S_REQ; pc is unchanged.
  - S_HOLD: when id_ready=1, move the buffer to IF/ID (id_pc = PC before advance, kept in buffer), go to S_REQ.
- Decode handshake: id_valid && id_ready with no refill clears id_valid next cycle. id_* outputs are stable while id_valid && !id_ready.
- flush=1, in any state, overrides all of the above in the same edge:
  - pc<=flush_target, id_valid<=0, buffer cleared, state<=S_REQ.
  - drop<=1 if a request is outstanding (state S_WAIT with no rvalid this cycle, or imem_req=1 this cycle).
  - flush together with imem_rvalid in the same cycle: data discarded, drop stays 0.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory latency. No request is issued while drop=1 is pending.
- Address arithmetic: the unit never adds to pc itself; npc and flush_target are used verbatim.
- Reset asserted mid-request: the returning imem_rvalid after reset release must be ignored. Rule: imem_rvalid in S_REQ or S_HOLD is ignored.

Optional Feature:
- Macro: FETCH_ADEL_CHECK_EN.
- Defined:
  - In S_REQ, if pc[1:0]!=0 or pc<IM_LO or pc>IM_HI, no imem_req is issued.
  - When slot_free, IF/ID is loaded directly with id_instr=32'h0, id_exc=1, id_pc=pc, and pc<=npc.
  - id_exc is cleared on any normal load.
- Not defined: no check is made; id_exc is tied to 0 and bad addresses are requested normally.

Decomposition:
- Shared package: state encoding (S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2), PC_RESET/IM_LO/IM_HI defaults, NOP word 32'h0.
- Natural sub-module: if_id_reg, the IF/ID register plus one-entry skid buffer with valid/ready and flush clear. The FSM and PC register stay in the top module.

Test Plan:
1. Reset release, npc=pc+4 looped, 1-cycle memory, id_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008 on every other cycle; id_pc follows with matching id_instr.
2. id_ready=0 for 5 cycles after first delivery -> second word held in buffer (S_HOLD), id_* stable, no new imem_req. id_ready=1 -> second instr (id_pc 0x3004) appears next cycle.
3. flush=1 with flush_target=0x3100 while in S_WAIT with memory latency 3 -> stale response discarded, next imem_addr=0x3100, id_valid=0 until 0x3100 data returns.
4. flush and imem_rvalid in the same cycle -> no IF/ID load, drop remains 0, next request to flush_target on the following cycle.
5. FETCH_ADEL_CHECK_EN defined, flush_target=0x3002 -> no imem_req; IF/ID gets instr 0x0, id_exc=1, id_pc=0x3002. Same address without the macro -> normal request to 0x3002, id_exc=0.
6. reset_n pulsed low while in S_WAIT, then memory returns rvalid after release -> response ignored, pc=0x3000, first request reissued.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared definitions for the instruction-fetch stage:
//                FSM state encoding, default PC / legal fetch window, the
//                NOP word loaded on an address fault, and the address-fault
//                helper used when FETCH_ADEL_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] S_REQ  = 2'd0;  // ready to issue a request
    localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding
    localparam logic [1:0] S_HOLD = 2'd2;  // response parked in skid buffer

    // Default configuration values
    localparam logic [31:0] C_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] C_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] C_IM_HI    = 32'h0000_6FFC;

    // Instruction word substituted for a faulting fetch
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    // Fetch address error: misaligned word or outside [lo, hi]
    function automatic logic adel_fault(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if_id_reg
//  Description : IF/ID pipeline register with a one-entry skid buffer.
//                An incoming word goes straight into IF/ID when the slot is
//                free (empty or being consumed this cycle); otherwise it is
//                parked in the buffer and moved to IF/ID when decode takes
//                the current entry. Flush empties both entries.
//  Ports       : clk, reset_n       - clock, async active-low reset
//                i_flush            - discard IF/ID and buffer contents
//                i_in_valid         - new entry offered this cycle
//                i_in_instr/pc/exc  - new entry payload
//                i_id_ready         - decode consumes IF/ID this cycle
//                o_slot_free        - IF/ID can accept a word this cycle
//                o_id_valid/instr/pc/exc - IF/ID register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_if_id_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_flush,
    input  logic        i_in_valid,
    input  logic [31:0] i_in_instr,
    input  logic [31:0] i_in_pc,
    input  logic        i_in_exc,
    input  logic        i_id_ready,
    output logic        o_slot_free,
    output logic        o_id_valid,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic        o_id_exc
);

    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic        r_id_exc;

    logic        r_buf_valid;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_buf_exc;

    assign o_slot_free = !r_id_valid || i_id_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_id_valid  <= 1'b0;
            r_id_instr  <= 32'h0;
            r_id_pc     <= 32'h0;
            r_id_exc    <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_instr <= 32'h0;
            r_buf_pc    <= 32'h0;
            r_buf_exc   <= 1'b0;
        end else if (i_flush) begin
            r_id_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else if (r_buf_valid) begin
            // The fetch FSM issues nothing while the buffer is occupied,
            // so only the drain path needs handling here.
            if (i_id_ready) begin
                r_id_valid  <= 1'b1;
                r_id_instr  <= r_buf_instr;
                r_id_pc     <= r_buf_pc;
                r_id_exc    <= r_buf_exc;
                r_buf_valid <= 1'b0;
            end
        end else if (i_in_valid) begin
            if (o_slot_free) begin
                r_id_valid <= 1'b1;
                r_id_instr <= i_in_instr;
                r_id_pc    <= i_in_pc;
                r_id_exc   <= i_in_exc;
            end else begin
                r_buf_valid <= 1'b1;
                r_buf_instr <= i_in_instr;
                r_buf_pc    <= i_in_pc;
                r_buf_exc   <= i_in_exc;
            end
        end else if (i_id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign o_id_valid = r_id_valid;
    assign o_id_instr = r_id_instr;
    assign o_id_pc    = r_id_pc;
    assign o_id_exc   = r_id_exc;

endmodule : fetch_unit_if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC register, issues one
//                outstanding read at a time to instruction memory, and
//                hands {instr, pc} to decode through a valid/ready IF/ID
//                register. Flush redirects the PC; a response belonging to
//                a request that was in flight at flush time is dropped.
//                Optional address-error check: define FETCH_ADEL_CHECK_EN
//                to turn misaligned / out-of-window fetches into a NOP with
//                id_exc=1 instead of a memory request (IM_LO / IM_HI exist
//                only in that build).
//  Ports       : clk, reset_n             - clock, async active-low reset
//                npc / pc                 - next PC in, current PC out
//                flush, flush_target      - redirect request and new PC
//                imem_req/addr/rvalid/rdata - instruction memory interface
//                id_valid/ready/instr/pc/exc - IF/ID handshake and payload
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = C_PC_RESET
`ifdef FETCH_ADEL_CHECK_EN
    ,
    parameter logic [31:0] IM_LO    = C_IM_LO,
    parameter logic [31:0] IM_HI    = C_IM_HI
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_exc
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_drop;     // a stale response is still owed by memory
    logic        r_run;      // low from reset until the first clock edge

    logic        w_slot_free;
    logic        w_addr_bad;
    logic        w_req_ok;
    logic        w_issue;
    logic        w_adel_load;
    logic        w_accept;
    logic        w_in_valid;
    logic [31:0] w_in_instr;

`ifdef FETCH_ADEL_CHECK_EN
    assign w_addr_bad = adel_fault(r_pc, IM_LO, IM_HI);
`else
    assign w_addr_bad = 1'b0;
`endif

    // The strobe is formed in the S_REQ cycle itself so that a 1-cycle
    // memory can sustain one instruction every two cycles. r_run keeps the
    // strobe low while reset is asserted.
    assign w_req_ok    = r_run && (r_state == S_REQ) && !r_drop && w_slot_free;
    assign w_issue     = w_req_ok && !w_addr_bad;
    assign w_adel_load = w_req_ok && w_addr_bad;

    // Only S_WAIT listens to rvalid; anything arriving in S_REQ (other than
    // the owed stale response) or S_HOLD is ignored.
    assign w_accept    = (r_state == S_WAIT) && imem_rvalid && !r_drop;

    assign w_in_valid  = !flush && (w_accept || w_adel_load);
    assign w_in_instr  = w_adel_load ? C_NOP : imem_rdata;

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_REQ;
            r_pc    <= PC_RESET;
            r_drop  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                r_state <= S_REQ;
                r_pc    <= flush_target;
                // Still owed a response if a request goes out now, or one
                // was already in flight and has not come back this cycle.
                r_drop  <= w_issue ||
                           (!imem_rvalid && (r_drop || (r_state == S_WAIT)));
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (r_drop) begin
                            if (imem_rvalid) begin
                                r_drop <= 1'b0;
                            end
                        end else if (w_issue) begin
                            r_state <= S_WAIT;
                        end else if (w_adel_load) begin
                            r_pc <= npc;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (r_drop) begin
                                r_drop  <= 1'b0;
                                r_state <= S_REQ;
                            end else begin
                                r_pc    <= npc;
                                r_state <= w_slot_free ? S_REQ : S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (id_ready) begin
                            r_state <= S_REQ;
                        end
                    end
                    default: begin
                        r_state <= S_REQ;
                    end
                endcase
            end
        end
    end

    fetch_unit_if_id_reg u_if_id (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_in_valid  (w_in_valid),
        .i_in_instr  (w_in_instr),
        .i_in_pc     (r_pc),
        .i_in_exc    (w_adel_load),
        .i_id_ready  (id_ready),
        .o_slot_free (w_slot_free),
        .o_id_valid  (id_valid),
        .o_id_instr  (id_instr),
        .o_id_pc     (id_pc),
        .o_id_exc    (id_exc)
    );

endmodule : fetch_unit
`default_nettype wire
